dma_channel_scheduler: RTL
==========================

# dma_channel_scheduler

Burst-level scheduler that shares the single DMA transfer engine between the CH_NUM DMA channels. Each channel raises a request with a burst length. The scheduler picks one winner by round-robin, holds the grant for the whole burst while counting engine beats, then rotates priority. It sits between the per-channel descriptor logic and the transfer engine.

## Interface
- CH_NUM, 4, number of channels (≥2)
- LEN_W, 8, width of burst length field (length encoded as beats−1)
- IDX_W, 2, width of channel index; must equal $clog2(CH_NUM)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ch_req  in  CH_NUM  channel i has a burst pending; level, sampled only in IDLE
- ch_len  in  CH_NUM*LEN_W  channel i burst length−1 at [i*LEN_W +: LEN_W]; sampled with the grant
- ch_urgent  in  CH_NUM  urgent qualifier per channel; used only under DMA_SCHED_PRIO_EN
- ch_gnt  out  CH_NUM  one-hot grant, held from START through the last beat
- ch_done  out  CH_NUM  one-hot, one-cycle pulse in the cycle the last beat is accepted
- eng_start  out  1  one-cycle pulse: engine begins the burst
- eng_ch  out  IDX_W  index of the granted channel, stable while ch_gnt≠0
- eng_len  out  LEN_W  latched beats−1 of the granted burst
- beat_valid  in  1  engine beat valid
- beat_ready  in  1  engine beat ready; a beat transfers when both are high
- busy  out  1  high in START and BURST

## Operation
- State machine: IDLE, START, BURST.
- IDLE:
  - If any ch_req is eligible, compute winner W = first requester at or above priority pointer P, wrapping cyclically.
  - Register ch_gnt=onehot(W), eng_ch=W, eng_len=ch_len[W]. Go to START.
  - If no request is eligible, stay in IDLE.
- START: eng_start=1 for exactly this cycle. Clear the beat counter. Go to BURST. Beats in START are ignored and not counted.
- BURST:
  - Each beat (beat_valid&beat_ready) increments the counter.
  - On the beat where counter==eng_len: pulse ch_done[W], set P=onehot((W+1) mod CH_NUM), go to IDLE.
  - beat_valid without beat_ready does not count.
- P changes only on burst completion. Reset value of P: onehot(0).
- A requester deasserting ch_req during START/BURST has no effect. The burst runs to completion.
- eng_len=0 means a 1-beat burst. eng_len=2^LEN_W−1 means a 2^LEN_W-beat burst. The counter is LEN_W bits and never wraps within a burst.
- After burst by channel CH_NUM−1, P wraps to channel 0.
- A requester that is still active re-competes in the next IDLE with the rotated P. Starvation bound: CH_NUM−1 bursts.

## Timing
- Reset values: ch_gnt=0, ch_done=0, eng_start=0, eng_ch=0, eng_len=0, busy=0, state IDLE, P=onehot(0), counter=0.
- Request in IDLE at cycle N: ch_gnt, eng_ch, eng_len, eng_start and busy are high/valid at N+1 (registered).
- First countable beat: cycle N+2.
- Last beat accepted at cycle M: ch_done pulses at M (combinational from the registered state plus the beat). ch_gnt and busy drop at M+1.
- The scheduler is in IDLE at M+1. The next grant is at M+2 at the earliest. One idle cycle separates back-to-back bursts.
- Reset mid-burst: all outputs return to reset values asynchronously. No ch_done is issued. P returns to channel 0.

## Configuration
- DMA_SCHED_PRIO_EN defined:
  - In IDLE, if (ch_req&ch_urgent)≠0, round-robin from P runs over urgent requesters only. Otherwise it runs over all requesters.
  - P rotates after every burst, urgent or not.
- DMA_SCHED_PRIO_EN undefined: ch_urgent is ignored (port kept, unconnected internally). Arbitration is plain round-robin.

## Test plan
- Reset, ch_req=0001, ch_len[0]=3, beats every cycle from START+1:
  - eng_start pulses 1 cycle after request; eng_ch=0, eng_len=3.
  - ch_done=0001 on the 4th beat; ch_gnt=0 the next cycle; P=0010.
- ch_req=1111 held, all lengths 0: grants in order ch0, ch1, ch2, ch3, ch0, each 3 cycles apart (START, BURST, IDLE).
- Last grant ch3, then ch_req=1001: the next grant is ch0 (wrap-around), not ch3.
- ch_req[1] dropped after grant, beat_ready toggling 1010…, eng_len=2: exactly 3 accepted beats end the burst. Unaccepted cycles are not counted. ch_done=0010.
- rstn asserted in BURST after 2 of 5 beats: all outputs 0 immediately, no ch_done. After release with ch_req=0100, ch2 is granted (P=ch0, first requester).
- With DMA_SCHED_PRIO_EN, P=ch0, ch_req=0011, ch_urgent=0010: ch1 is granted. Without the macro, ch0 is granted.

Source files
------------

// File: rtl/dma_channel_scheduler.sv
// Round-robin burst scheduler sharing one DMA transfer engine between CH_NUM channels.
// Optional urgent-first arbitration is enabled by defining DMA_SCHED_PRIO_EN.
module dma_channel_scheduler #(
    parameter int CH_NUM = 4,
    parameter int LEN_W  = 8,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [CH_NUM-1:0]       ch_req,
    input  logic [CH_NUM*LEN_W-1:0] ch_len,
    input  logic [CH_NUM-1:0]       ch_urgent,
    output logic [CH_NUM-1:0]       ch_gnt,
    output logic [CH_NUM-1:0]       ch_done,
    output logic                    eng_start,
    output logic [IDX_W-1:0]        eng_ch,
    output logic [LEN_W-1:0]        eng_len,
    input  logic                    beat_valid,
    input  logic                    beat_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BURST} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_NUM-1:0]   r_ptr;
    logic [CH_NUM-1:0]   r_gnt;
    logic [IDX_W-1:0]    r_ch;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;

    logic [CH_NUM-1:0]   w_elig;
    logic [IDX_W-1:0]    w_ptr_idx;
    logic [IDX_W-1:0]    w_win;
    logic                w_found;
    logic                w_beat;
    logic                w_last;

    // Cyclic (a + b) mod CH_NUM; one extra bit holds the sum before wrapping.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + (IDX_W+1)'(b);
        if (s >= (IDX_W+1)'(CH_NUM))
            s = s - (IDX_W+1)'(CH_NUM);
        return s[IDX_W-1:0];
    endfunction

`ifdef DMA_SCHED_PRIO_EN
    logic [CH_NUM-1:0] w_urg_req;
    assign w_urg_req = ch_req & ch_urgent;
    assign w_elig    = (|w_urg_req) ? w_urg_req : ch_req;
`else
    logic w_unused_urgent;
    assign w_unused_urgent = ^ch_urgent;
    assign w_elig          = ch_req;
`endif

    always_comb begin
        w_ptr_idx = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (r_ptr[i]) w_ptr_idx = IDX_W'(i);
    end

    // Scan from the pointer position outward; the first eligible channel wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!w_found && w_elig[wrap_add(w_ptr_idx, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(w_ptr_idx, i);
            end
        end
    end

    assign w_beat = beat_valid & beat_ready;
    assign w_last = (r_state == S_BURST) && w_beat && (r_cnt == r_len);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ch_done     = '0;
        eng_start   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_START;
            end
            S_START: begin
                eng_start   = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_BURST;
            end
            S_BURST: begin
                busy = 1'b1;
                if (w_last) begin
                    ch_done     = r_gnt;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, length and pointer only move at burst boundaries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gnt <= '0;
            r_ch  <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_ptr <= CH_NUM'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt <= CH_NUM'(1) << w_win;
                        r_ch  <= w_win;
                        r_len <= ch_len[int'(w_win)*LEN_W +: LEN_W];
                    end
                end
                S_START: r_cnt <= '0;
                S_BURST: begin
                    if (w_beat) begin
                        if (r_cnt == r_len) begin
                            r_gnt <= '0;
                            r_ptr <= CH_NUM'(1) << wrap_add(r_ch, 1);
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ch_gnt  = r_gnt;
    assign eng_ch  = r_ch;
    assign eng_len = r_len;

endmodule
